ysyx_23060184_mem_arbiter: RTL
==============================

# ysyx_23060184_mem_arbiter

Two-master AXI4 arbiter that shares the single memory-side AXI4 port between the instruction fetch unit (IFU, master 0) and the load/store unit (LSU, master 1). It samples the requesters' `Irequest`/`Drequest` lines and publishes the encoded `grant` bus that both masters qualify their handshakes with. It routes the granted master's AR/R (and, for the LSU, AW/W/B) channels to memory. It holds the grant until the granted transaction's final response handshake.

## Interface
Parameters:
- `ROUND_ROBIN`, default 1: 1 = alternate masters on simultaneous requests; 0 = LSU always wins ties.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  reset, synchronous and active-high.
- `Irequest`  in  1  IFU wants the bus.
- `Drequest`  in  1  LSU wants the bus.
- `grant`  out  `NUM_ARB_MASTERS`  encoded owner: `ARB_IDLE` (2'b00), `INSTMEM_GRANT` (2'b01), `LSU_GRANT` (2'b10).
- `i_araddr, i_arid, i_arlen, i_arsize, i_arburst, i_arvalid`  in  `DATA_WIDTH`/`ID_WIDTH`/`ALEN`/`ASIZE`/`ABURST`/1  IFU AR channel.
- `i_arready`  out  1  IFU AR ready.
- `i_rdata, i_rresp, i_rvalid`  out  `DATA_WIDTH`/`ACERR_WIDTH`/1  IFU R channel.
- `i_rready`  in  1  IFU R ready.
- `d_ar*`, `d_r*`  same set as the IFU AR/R ports  LSU read channels.
- `d_awaddr, d_awid, d_awlen, d_awsize, d_awburst, d_awvalid`, `d_wdata, d_wstrb, d_wlast, d_wvalid`, `d_bready`  in  LSU write request.
- `d_awready, d_wready, d_bresp, d_bvalid`  out  LSU write response.
- `mem_*`  out/in (mirrored)  the full AXI4 master port toward memory, including `mem_rlast`, `mem_rid`, `mem_bid`.

## Operation
- FSM states: IDLE, OWN_I, OWN_D. `grant` is decoded directly from the state register, so it is a glitch-free register output.
- IDLE:
  - Only `Irequest` high → OWN_I.
  - Only `Drequest` high → OWN_D.
  - Both high, `ROUND_ROBIN`=1 → grant the master not recorded in `last_owner`.
  - Both high, `ROUND_ROBIN`=0 → OWN_D.
  - `last_owner` resets to LSU, so the IFU wins the first tie after reset.
- OWN_I:
  - AR/R muxed to the IFU.
  - All LSU-facing valid/ready outputs forced to 0.
  - `mem_aw*` and `mem_w*` valids forced to 0.
- OWN_D:
  - AR/R/AW/W/B muxed to the LSU.
  - IFU-facing `i_arready` and `i_rvalid` forced to 0.
- Data/payload outputs toward the non-owner are driven 0.
- Completion:
  - Read: `mem_rvalid && mem_rready && mem_rlast`.
  - Write: `mem_bvalid && mem_bready`.
  - On completion the FSM moves to IDLE and `last_owner` updates to the finishing master.
  - An error `rresp`/`bresp` still completes the transaction and is passed through unchanged.
- Abandon: if the owner drops its request while no AR/AW handshake has occurred, return to IDLE and leave `last_owner` unchanged.
  - A per-grant `addr_done` flag records that an address handshake took place.
  - Once `addr_done` is set, a dropped request is ignored until completion.
- One outstanding transaction at a time. Read and write are never concurrently granted.

## Timing
- Grant latency: request high in cycle N (FSM in IDLE) → `grant` valid in cycle N+1.
- Release: completion handshake in cycle M → `grant`=`ARB_IDLE` in M+1.
  - The earliest next grant is M+2, giving a guaranteed one-cycle bus turnaround.
  - Back-to-back alternate-master ownership therefore costs exactly one idle cycle.
- Channel muxing is combinational from the state register. No added latency on AR, R, AW, W, B.
- Reset values: state IDLE, `grant`=0, `last_owner`=LSU, `addr_done`=0.
  - All `mem_*valid` and `mem_*ready` outputs are 0.
  - All master-facing valid/ready outputs are 0.
- Reset asserted mid-transaction aborts ownership on the next edge. Memory is expected to be reset by the same signal.
- Request and completion in the same IDLE cycle cannot occur, because completion only exists while owned.

## Structure
- Shared package/header:
  - `ARB_IDLE`, `INSTMEM_GRANT`, `LSU_GRANT`, `NUM_ARB_MASTERS`.
  - AXI width macros already in use (`DATA_WIDTH`, `ID_WIDTH`, `ALEN`, `ASIZE`, `ABURST`, `ACERR_WIDTH`).
  - FSM state encodings.
- One natural sub-module: `ysyx_23060184_axi_chan_mux`, the combinational 2:1 channel steering block driven by `grant`. The FSM and `last_owner` stay in the top.

## Test plan
- Single IFU read:
  - Stimulus: `Irequest`=1 at cycle 2, AR to 0x8000_0000, memory returns rdata 0x0000_0413 with rlast.
  - Required: `grant`=01 at cycle 3, data reaches `i_rdata`, `grant`=00 one cycle after the R handshake.
- Simultaneous requests after reset, `ROUND_ROBIN`=1:
  - Stimulus: both requests high.
  - Required: IFU granted first, LSU granted two cycles after the IFU completion.
  - Repeat: next tie goes to the IFU again, since `last_owner`=LSU.
- `ROUND_ROBIN`=0:
  - Stimulus: both requests held high for 3 transactions.
  - Required: LSU granted every time, IFU never granted.
- LSU write:
  - Stimulus: AW 0x8000_1000, W 0xDEAD_BEEF, `wstrb` 0xF, bresp SLVERR.
  - Required: `d_bresp`=SLVERR, grant released after the B handshake, IFU AR held off throughout (`i_arready`=0).
- Abandon:
  - Stimulus: `Drequest` pulses one cycle with no AW/AR handshake.
  - Required: return to IDLE, `last_owner` unchanged.
  - Follow-up: the same pulse after the AR handshake must keep the grant until rlast.
- Reset mid-read:
  - Stimulus: `reset` asserted between the AR and R handshakes.
  - Required: next cycle `grant`=0 and all valids 0.
  - Required: a subsequent `Irequest` is granted normally.

Source files
------------

// File: rtl/ysyx_23060184_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060184_mem_arbiter_pkg
// Brief    : Shared widths, grant encodings and FSM state encodings for the
//            IFU/LSU memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_23060184_mem_arbiter_pkg;

   // AXI4 field widths used across the core
   localparam int DATA_WIDTH      = 32;
   localparam int ID_WIDTH        = 4;
   localparam int ALEN            = 8;
   localparam int ASIZE           = 3;
   localparam int ABURST          = 2;
   localparam int ACERR_WIDTH     = 2;
   localparam int STRB_WIDTH      = DATA_WIDTH / 8;

   // Grant bus encoding published to both masters
   localparam int NUM_ARB_MASTERS = 2;
   localparam logic [NUM_ARB_MASTERS-1:0] ARB_IDLE      = 2'b00;
   localparam logic [NUM_ARB_MASTERS-1:0] INSTMEM_GRANT = 2'b01;
   localparam logic [NUM_ARB_MASTERS-1:0] LSU_GRANT     = 2'b10;

   // FSM states share the grant encoding so grant is the state register itself
   localparam logic [1:0] ST_IDLE  = ARB_IDLE;
   localparam logic [1:0] ST_OWN_I = INSTMEM_GRANT;
   localparam logic [1:0] ST_OWN_D = LSU_GRANT;

   // Identity of the master that most recently completed a transaction
   localparam logic OWNER_IFU = 1'b0;
   localparam logic OWNER_LSU = 1'b1;

   // Winner of a simultaneous request
   function automatic logic [1:0] tie_winner(input logic rr, input logic last_owner);
      if (rr && (last_owner == OWNER_LSU)) begin
         return ST_OWN_I;
      end
      return ST_OWN_D;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_23060184_axi_chan_mux.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060184_axi_chan_mux
// Brief    : Combinational 2:1 AXI4 channel steering between IFU and LSU,
//            selected by the registered grant. Non-owners see all zeros.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060184_axi_chan_mux
   import ysyx_23060184_mem_arbiter_pkg::*;
(
   input  logic [NUM_ARB_MASTERS-1:0] grant,
   // IFU read channels
   input  logic [DATA_WIDTH-1:0]      i_araddr,
   input  logic [ID_WIDTH-1:0]        i_arid,
   input  logic [ALEN-1:0]            i_arlen,
   input  logic [ASIZE-1:0]           i_arsize,
   input  logic [ABURST-1:0]          i_arburst,
   input  logic                       i_arvalid,
   output logic                       i_arready,
   output logic [DATA_WIDTH-1:0]      i_rdata,
   output logic [ACERR_WIDTH-1:0]     i_rresp,
   output logic                       i_rvalid,
   input  logic                       i_rready,
   // LSU read channels
   input  logic [DATA_WIDTH-1:0]      d_araddr,
   input  logic [ID_WIDTH-1:0]        d_arid,
   input  logic [ALEN-1:0]            d_arlen,
   input  logic [ASIZE-1:0]           d_arsize,
   input  logic [ABURST-1:0]          d_arburst,
   input  logic                       d_arvalid,
   output logic                       d_arready,
   output logic [DATA_WIDTH-1:0]      d_rdata,
   output logic [ACERR_WIDTH-1:0]     d_rresp,
   output logic                       d_rvalid,
   input  logic                       d_rready,
   // LSU write channels
   input  logic [DATA_WIDTH-1:0]      d_awaddr,
   input  logic [ID_WIDTH-1:0]        d_awid,
   input  logic [ALEN-1:0]            d_awlen,
   input  logic [ASIZE-1:0]           d_awsize,
   input  logic [ABURST-1:0]          d_awburst,
   input  logic                       d_awvalid,
   output logic                       d_awready,
   input  logic [DATA_WIDTH-1:0]      d_wdata,
   input  logic [STRB_WIDTH-1:0]      d_wstrb,
   input  logic                       d_wlast,
   input  logic                       d_wvalid,
   output logic                       d_wready,
   output logic [ACERR_WIDTH-1:0]     d_bresp,
   output logic                       d_bvalid,
   input  logic                       d_bready,
   // Memory-side port
   output logic [DATA_WIDTH-1:0]      mem_araddr,
   output logic [ID_WIDTH-1:0]        mem_arid,
   output logic [ALEN-1:0]            mem_arlen,
   output logic [ASIZE-1:0]           mem_arsize,
   output logic [ABURST-1:0]          mem_arburst,
   output logic                       mem_arvalid,
   input  logic                       mem_arready,
   input  logic [DATA_WIDTH-1:0]      mem_rdata,
   input  logic [ACERR_WIDTH-1:0]     mem_rresp,
   input  logic                       mem_rvalid,
   output logic                       mem_rready,
   output logic [DATA_WIDTH-1:0]      mem_awaddr,
   output logic [ID_WIDTH-1:0]        mem_awid,
   output logic [ALEN-1:0]            mem_awlen,
   output logic [ASIZE-1:0]           mem_awsize,
   output logic [ABURST-1:0]          mem_awburst,
   output logic                       mem_awvalid,
   input  logic                       mem_awready,
   output logic [DATA_WIDTH-1:0]      mem_wdata,
   output logic [STRB_WIDTH-1:0]      mem_wstrb,
   output logic                       mem_wlast,
   output logic                       mem_wvalid,
   input  logic                       mem_wready,
   input  logic [ACERR_WIDTH-1:0]     mem_bresp,
   input  logic                       mem_bvalid,
   output logic                       mem_bready
);

   // Steer every channel to the owner; everything defaults to zero when idle
   always_comb begin
      i_arready   = 1'b0;
      i_rdata     = '0;
      i_rresp     = '0;
      i_rvalid    = 1'b0;
      d_arready   = 1'b0;
      d_rdata     = '0;
      d_rresp     = '0;
      d_rvalid    = 1'b0;
      d_awready   = 1'b0;
      d_wready    = 1'b0;
      d_bresp     = '0;
      d_bvalid    = 1'b0;
      mem_araddr  = '0;
      mem_arid    = '0;
      mem_arlen   = '0;
      mem_arsize  = '0;
      mem_arburst = '0;
      mem_arvalid = 1'b0;
      mem_rready  = 1'b0;
      mem_awaddr  = '0;
      mem_awid    = '0;
      mem_awlen   = '0;
      mem_awsize  = '0;
      mem_awburst = '0;
      mem_awvalid = 1'b0;
      mem_wdata   = '0;
      mem_wstrb   = '0;
      mem_wlast   = 1'b0;
      mem_wvalid  = 1'b0;
      mem_bready  = 1'b0;
      case (grant)
         INSTMEM_GRANT: begin
            // IFU only issues reads; write channels stay quiet
            mem_araddr  = i_araddr;
            mem_arid    = i_arid;
            mem_arlen   = i_arlen;
            mem_arsize  = i_arsize;
            mem_arburst = i_arburst;
            mem_arvalid = i_arvalid;
            i_arready   = mem_arready;
            i_rdata     = mem_rdata;
            i_rresp     = mem_rresp;
            i_rvalid    = mem_rvalid;
            mem_rready  = i_rready;
         end
         LSU_GRANT: begin
            mem_araddr  = d_araddr;
            mem_arid    = d_arid;
            mem_arlen   = d_arlen;
            mem_arsize  = d_arsize;
            mem_arburst = d_arburst;
            mem_arvalid = d_arvalid;
            d_arready   = mem_arready;
            d_rdata     = mem_rdata;
            d_rresp     = mem_rresp;
            d_rvalid    = mem_rvalid;
            mem_rready  = d_rready;
            mem_awaddr  = d_awaddr;
            mem_awid    = d_awid;
            mem_awlen   = d_awlen;
            mem_awsize  = d_awsize;
            mem_awburst = d_awburst;
            mem_awvalid = d_awvalid;
            d_awready   = mem_awready;
            mem_wdata   = d_wdata;
            mem_wstrb   = d_wstrb;
            mem_wlast   = d_wlast;
            mem_wvalid  = d_wvalid;
            d_wready    = mem_wready;
            d_bresp     = mem_bresp;
            d_bvalid    = mem_bvalid;
            mem_bready  = d_bready;
         end
         default: begin
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/ysyx_23060184_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060184_mem_arbiter
// Brief    : Two-master AXI4 arbiter (IFU = master 0, LSU = master 1) sharing
//            one memory port. Holds grant until the final response handshake.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060184_mem_arbiter
   import ysyx_23060184_mem_arbiter_pkg::*;
#(
   parameter int ROUND_ROBIN = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       Irequest,
   input  logic                       Drequest,
   output logic [NUM_ARB_MASTERS-1:0] grant,
   input  logic [DATA_WIDTH-1:0]      i_araddr,
   input  logic [ID_WIDTH-1:0]        i_arid,
   input  logic [ALEN-1:0]            i_arlen,
   input  logic [ASIZE-1:0]           i_arsize,
   input  logic [ABURST-1:0]          i_arburst,
   input  logic                       i_arvalid,
   output logic                       i_arready,
   output logic [DATA_WIDTH-1:0]      i_rdata,
   output logic [ACERR_WIDTH-1:0]     i_rresp,
   output logic                       i_rvalid,
   input  logic                       i_rready,
   input  logic [DATA_WIDTH-1:0]      d_araddr,
   input  logic [ID_WIDTH-1:0]        d_arid,
   input  logic [ALEN-1:0]            d_arlen,
   input  logic [ASIZE-1:0]           d_arsize,
   input  logic [ABURST-1:0]          d_arburst,
   input  logic                       d_arvalid,
   output logic                       d_arready,
   output logic [DATA_WIDTH-1:0]      d_rdata,
   output logic [ACERR_WIDTH-1:0]     d_rresp,
   output logic                       d_rvalid,
   input  logic                       d_rready,
   input  logic [DATA_WIDTH-1:0]      d_awaddr,
   input  logic [ID_WIDTH-1:0]        d_awid,
   input  logic [ALEN-1:0]            d_awlen,
   input  logic [ASIZE-1:0]           d_awsize,
   input  logic [ABURST-1:0]          d_awburst,
   input  logic                       d_awvalid,
   output logic                       d_awready,
   input  logic [DATA_WIDTH-1:0]      d_wdata,
   input  logic [STRB_WIDTH-1:0]      d_wstrb,
   input  logic                       d_wlast,
   input  logic                       d_wvalid,
   output logic                       d_wready,
   output logic [ACERR_WIDTH-1:0]     d_bresp,
   output logic                       d_bvalid,
   input  logic                       d_bready,
   output logic [DATA_WIDTH-1:0]      mem_araddr,
   output logic [ID_WIDTH-1:0]        mem_arid,
   output logic [ALEN-1:0]            mem_arlen,
   output logic [ASIZE-1:0]           mem_arsize,
   output logic [ABURST-1:0]          mem_arburst,
   output logic                       mem_arvalid,
   input  logic                       mem_arready,
   input  logic [DATA_WIDTH-1:0]      mem_rdata,
   input  logic [ACERR_WIDTH-1:0]     mem_rresp,
   input  logic                       mem_rvalid,
   input  logic                       mem_rlast,
   input  logic [ID_WIDTH-1:0]        mem_rid,
   output logic                       mem_rready,
   output logic [DATA_WIDTH-1:0]      mem_awaddr,
   output logic [ID_WIDTH-1:0]        mem_awid,
   output logic [ALEN-1:0]            mem_awlen,
   output logic [ASIZE-1:0]           mem_awsize,
   output logic [ABURST-1:0]          mem_awburst,
   output logic                       mem_awvalid,
   input  logic                       mem_awready,
   output logic [DATA_WIDTH-1:0]      mem_wdata,
   output logic [STRB_WIDTH-1:0]      mem_wstrb,
   output logic                       mem_wlast,
   output logic                       mem_wvalid,
   input  logic                       mem_wready,
   input  logic [ACERR_WIDTH-1:0]     mem_bresp,
   input  logic                       mem_bvalid,
   input  logic [ID_WIDTH-1:0]        mem_bid,
   output logic                       mem_bready
);

   localparam logic c_rr = (ROUND_ROBIN != 0);

   logic [1:0] r_state;
   logic       r_last_owner;
   logic       r_addr_done;
   logic [1:0] w_state_nxt;
   logic       w_last_owner_nxt;
   logic       w_addr_done_nxt;
   logic       w_done;
   logic       w_addr_hs;
   logic       w_owner_req;
   logic       w_unused;

   // Only one transaction is ever in flight, so response IDs carry no routing information
   assign w_unused = ^{mem_rid, mem_bid};

   assign grant       = r_state;
   assign w_done      = (mem_rvalid & mem_rready & mem_rlast) | (mem_bvalid & mem_bready);
   assign w_addr_hs   = (mem_arvalid & mem_arready) | (mem_awvalid & mem_awready);
   assign w_owner_req = (r_state == ST_OWN_I) ? Irequest : Drequest;

   // Next-state: arbitrate in IDLE, release on completion or pre-address abandon
   always_comb begin
      w_state_nxt      = r_state;
      w_last_owner_nxt = r_last_owner;
      w_addr_done_nxt  = r_addr_done;
      case (r_state)
         ST_IDLE: begin
            w_addr_done_nxt = 1'b0;
            if (Irequest && Drequest) begin
               w_state_nxt = tie_winner(c_rr, r_last_owner);
            end else if (Irequest) begin
               w_state_nxt = ST_OWN_I;
            end else if (Drequest) begin
               w_state_nxt = ST_OWN_D;
            end
         end
         ST_OWN_I, ST_OWN_D: begin
            if (w_done) begin
               w_state_nxt      = ST_IDLE;
               w_last_owner_nxt = (r_state == ST_OWN_D) ? OWNER_LSU : OWNER_IFU;
               w_addr_done_nxt  = 1'b0;
            end else if (!w_owner_req && !r_addr_done && !w_addr_hs) begin
               // Request withdrawn before any address went out: nothing to finish
               w_state_nxt     = ST_IDLE;
               w_addr_done_nxt = 1'b0;
            end else if (w_addr_hs) begin
               w_addr_done_nxt = 1'b1;
            end
         end
         default: begin
            w_state_nxt     = ST_IDLE;
            w_addr_done_nxt = 1'b0;
         end
      endcase
   end

   // Arbiter state registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_last_owner <= OWNER_LSU;
         r_addr_done  <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_last_owner <= w_last_owner_nxt;
         r_addr_done  <= w_addr_done_nxt;
      end
   end

   ysyx_23060184_axi_chan_mux u_chan_mux (
      .grant       (r_state),
      .i_araddr    (i_araddr),
      .i_arid      (i_arid),
      .i_arlen     (i_arlen),
      .i_arsize    (i_arsize),
      .i_arburst   (i_arburst),
      .i_arvalid   (i_arvalid),
      .i_arready   (i_arready),
      .i_rdata     (i_rdata),
      .i_rresp     (i_rresp),
      .i_rvalid    (i_rvalid),
      .i_rready    (i_rready),
      .d_araddr    (d_araddr),
      .d_arid      (d_arid),
      .d_arlen     (d_arlen),
      .d_arsize    (d_arsize),
      .d_arburst   (d_arburst),
      .d_arvalid   (d_arvalid),
      .d_arready   (d_arready),
      .d_rdata     (d_rdata),
      .d_rresp     (d_rresp),
      .d_rvalid    (d_rvalid),
      .d_rready    (d_rready),
      .d_awaddr    (d_awaddr),
      .d_awid      (d_awid),
      .d_awlen     (d_awlen),
      .d_awsize    (d_awsize),
      .d_awburst   (d_awburst),
      .d_awvalid   (d_awvalid),
      .d_awready   (d_awready),
      .d_wdata     (d_wdata),
      .d_wstrb     (d_wstrb),
      .d_wlast     (d_wlast),
      .d_wvalid    (d_wvalid),
      .d_wready    (d_wready),
      .d_bresp     (d_bresp),
      .d_bvalid    (d_bvalid),
      .d_bready    (d_bready),
      .mem_araddr  (mem_araddr),
      .mem_arid    (mem_arid),
      .mem_arlen   (mem_arlen),
      .mem_arsize  (mem_arsize),
      .mem_arburst (mem_arburst),
      .mem_arvalid (mem_arvalid),
      .mem_arready (mem_arready),
      .mem_rdata   (mem_rdata),
      .mem_rresp   (mem_rresp),
      .mem_rvalid  (mem_rvalid),
      .mem_rready  (mem_rready),
      .mem_awaddr  (mem_awaddr),
      .mem_awid    (mem_awid),
      .mem_awlen   (mem_awlen),
      .mem_awsize  (mem_awsize),
      .mem_awburst (mem_awburst),
      .mem_awvalid (mem_awvalid),
      .mem_awready (mem_awready),
      .mem_wdata   (mem_wdata),
      .mem_wstrb   (mem_wstrb),
      .mem_wlast   (mem_wlast),
      .mem_wvalid  (mem_wvalid),
      .mem_wready  (mem_wready),
      .mem_bresp   (mem_bresp),
      .mem_bvalid  (mem_bvalid),
      .mem_bready  (mem_bready)
   );

endmodule
`default_nettype wire
